// File: rtl/io_arb_pkg.sv
// rtl/io_arb_pkg.sv - shared state encoding and constants for the I/O bus arbiter
package io_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Every bit of req_rdata takes this value when a stalled access is aborted.
    localparam logic TMO_RDATA_FILL = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first requester after a pointer
module rr_picker #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    // Scan cores above the pointer first, then wrap to cores at or below it.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i > int'(ptr_i))) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i <= int'(ptr_i))) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin sharing of one peripheral port among N cores (optional IO_TIMEOUT_EN)
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int N              = 3,
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    input  logic [N-1:0]    req_wr,
    input  logic [N-1:0]    req_rd,
    output logic [N-1:0]    req_ack,
    output logic [DW-1:0]   req_rdata,
    output logic [AW-1:0]   per_addr,
    output logic [DW-1:0]   per_wdata,
    output logic            per_wr,
    output logic            per_rd,
    input  logic [DW-1:0]   per_rdata,
    input  logic            per_rdy,
    output logic [IDW-1:0]  grant_id,
    output logic            busy,
    output logic            timeout_err
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           per_wr_q, per_wr_d;
    logic           per_rd_q, per_rd_d;
    logic           busy_q, busy_d;

    logic [N-1:0]   req_any;
    logic [N-1:0]   pick_gnt;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           sel_wr;

`ifdef IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           tmo_err_q, tmo_err_d;
`else
    logic           unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    assign req_any = req_wr | req_rd;

    rr_picker #(.N(N), .IDW(IDW)) u_picker (
        .req_i (req_any),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Mux the winning core's address, data and operation; write wins over read.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_wr    = req_wr[i];
            end
        end
    end

    // Next-state and registered-output logic for the grant/access/ack sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        per_wr_d = per_wr_q;
        per_rd_d = per_rd_q;
        busy_d   = busy_q;
`ifdef IO_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_ACCESS;
                    ptr_d    = pick_idx;
                    grant_d  = pick_idx;
                    gnt_d    = pick_gnt;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    per_wr_d = sel_wr;
                    per_rd_d = !sel_wr;
                    busy_d   = 1'b1;
`ifdef IO_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (per_rdy) begin
                    if (per_rd_q) begin
                        rdata_d = per_rdata;
                    end
                    per_wr_d = 1'b0;
                    per_rd_d = 1'b0;
                    ack_d    = gnt_q;
                    state_d  = ST_DONE;
                end
`ifdef IO_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d   = {DW{TMO_RDATA_FILL}};
                    tmo_err_d = 1'b1;
                    per_wr_d  = 1'b0;
                    per_rd_d  = 1'b0;
                    ack_d     = gnt_q;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDW'(N - 1);
            grant_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            per_wr_q <= 1'b0;
            per_rd_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            per_wr_q <= per_wr_d;
            per_rd_q <= per_rd_d;
            busy_q   <= busy_d;
        end
    end

`ifdef IO_TIMEOUT_EN
    // Stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;
    assign per_addr  = addr_q;
    assign per_wdata = wdata_q;
    assign per_wr    = per_wr_q;
    assign per_rd    = per_rd_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares one peripheral I/O port (LED bank, UART, GPIO) among N TinyComp cores. Removes the need for per-core address decode and per-core peripheral copies.
- Each core presents a read/write request with address and data. The arbiter grants one request at a time in round-robin order and sequences a single peripheral access.
- It returns read data plus a one-cycle acknowledge to the winning core.
- Sits between the TinyComp I/O strobes and the shared peripheral decode in the top level.

Parameters:
- N, 3, number of requesting cores (2..8)
- AW, 32, I/O address width
- DW, 32, I/O data width
- IDW, 2, grant index width, at least clog2(N)
- TIMEOUT_CYCLES, 255, peripheral wait limit (used only with IO_TIMEOUT_EN)

Ports:
- clk  in  1  single system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req_addr  in  N*AW  request addresses; core i occupies bits [i*AW +: AW]
- req_wdata  in  N*DW  write data per core, same packing
- req_wr  in  N  write request, level, held until ack
- req_rd  in  N  read request, level, held until ack
- req_ack  out  N  one-hot, one-cycle completion pulse
- req_rdata  out  DW  read data; valid in the ack cycle; broadcast to all cores
- per_addr  out  AW  peripheral address
- per_wdata  out  DW  peripheral write data
- per_wr  out  1  peripheral write strobe, held until per_rdy
- per_rd  out  1  peripheral read strobe, held until per_rdy
- per_rdata  in  DW  peripheral read data, sampled when per_rdy=1
- per_rdy  in  1  peripheral completion; may be tied 1
- grant_id  out  IDW  index of the current or last-granted core
- busy  out  1  high in ACCESS and DONE
- timeout_err  out  1  sticky timeout flag; tied 0 without IO_TIMEOUT_EN

Behaviour:
- Reset values:
  - req_ack=0, req_rdata=0
  - per_addr=0, per_wdata=0, per_wr=0, per_rd=0
  - grant_id=0, busy=0, timeout_err=0
  - state=IDLE, round-robin pointer=N-1, so core 0 has top priority after reset
- All outputs are registered.
- A core is requesting when req_wr[i] | req_rd[i]. If both are high, the request is a write and req_rd is ignored.
- State machine:
  - IDLE: if any core is requesting, select the first requester after the pointer (wrapping from N-1 to 0). Latch its address, write data and operation. Set grant_id, pointer:=winner, enter ACCESS. With no requests, stay in IDLE.
  - ACCESS: drive per_addr/per_wdata and per_wr or per_rd (exactly one) every cycle. On the edge where per_rdy=1: for a read, capture per_rdata into req_rdata; deassert the strobes; set req_ack[grant_id]=1; enter DONE.
  - DONE: req_ack is high for exactly this one cycle. Next edge: req_ack:=0, enter IDLE.
- Latency with per_rdy tied 1: request sampled in cycle t, strobe high in t+1, ack high in t+2. Next grant in IDLE at t+3, so a back-to-back transaction costs 3 cycles.
- Requesters must deassert req in the ack cycle. In IDLE the arbiter samples only the live request.
- Request dropped before grant: never served, no ack.
- Request dropped or changed during ACCESS: ignored; the latched values complete the transaction.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0. No core waits more than N-1 transactions.
- Reset asserted mid-transaction: strobes and ack drop at that edge; the transaction is lost with no ack.
- req_rdata holds its last value until the next read completes. A write does not alter req_rdata.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with per_rdy=0.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: strobes drop, req_rdata:={DW{1'b1}}, timeout_err:=1 (sticky until Reset), normal ack via DONE.
- Undefined: no counter; ACCESS waits indefinitely for per_rdy; timeout_err is constant 0.

Decomposition:
- Package io_arb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - default AW/DW values
  - the timeout read value constant
- Sub-module rr_picker: combinational, N-bit request vector plus pointer in; one-hot grant plus index plus any_req out. Instantiated once.

Test Plan:
- Single write, per_rdy=1: core 1 req_wr with addr 0x3FF, data 0xA5 at cycle 0. Expect per_wr high in cycle 1 with per_addr=0x3FF and per_wdata=0xA5, and req_ack=3'b010 in cycle 2 only.
- Read with wait states: core 0 req_rd, per_rdy low for 4 cycles, then high with per_rdata=0x12345678. Expect per_rd held for 5 cycles, then req_rdata=0x12345678 together with req_ack[0].
- Round-robin: all 3 cores request continuously after reset. Expect grant_id sequence 0,1,2,0,1,2 and acks every 3 cycles.
- Simultaneous rd and wr on core 2: expect per_wr=1, per_rd=0, and req_rdata unchanged.
- Reset mid-ACCESS with per_rdy=0: expect per_wr=0 and busy=0 after the edge, no ack, and the next grant goes to core 0.
- With IO_TIMEOUT_EN and TIMEOUT_CYCLES=8, per_rdy stuck 0: expect ack after the timeout with req_rdata=0xFFFFFFFF and timeout_err=1 persisting through later transactions.
